// File: rtl/btn_event_gen.sv
// Key conditioner: synchronises and debounces S0/S2/S3, emits one-cycle press
// events and classifies S2 presses as short or long.
module btn_event_gen #(
  parameter int unsigned DB_CNT   = 3,
  parameter int unsigned LONG_CNT = 50
) (
  input  logic clk_db,
  input  logic rst_n,
  input  logic key_s0,
  input  logic key_s2,
  input  logic key_s3,
  output logic btn_left,
  output logic btn_right,
  output logic s2_short,
  output logic s2_long,
  output logic s2_held
);

  localparam int unsigned NKEY   = 3;
  localparam int unsigned K_S0   = 0;
  localparam int unsigned K_S2   = 1;
  localparam int unsigned K_S3   = 2;
  localparam int unsigned DB_W   = $clog2(DB_CNT + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CNT + 1);

  typedef enum logic [1:0] {
    S2_IDLE,
    S2_PRESSED,
    S2_LONG_FIRED
  } s2_state_e;

  logic [NKEY-1:0]           raw_c;
  logic [NKEY-1:0]           meta_q, meta_d;
  logic [NKEY-1:0]           sync_q, sync_d;
  logic [NKEY-1:0]           db_q, db_d;
  logic [NKEY-1:0][DB_W-1:0] cnt_q, cnt_d;
  logic [NKEY-1:0]           rise_c;
  logic                      s2_fall_c;

  s2_state_e                 state_q, state_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic                      btn_left_q, btn_left_d;
  logic                      btn_right_q, btn_right_d;
  logic                      s2_short_q, s2_short_d;
  logic                      s2_long_q, s2_long_d;

  assign raw_c = {key_s3, key_s2, key_s0};

  // Two-flop synchroniser and per-key debounce counters.
  always_comb begin
    meta_d = raw_c;
    sync_d = meta_q;
    db_d   = db_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(NKEY); i++) begin
      if (sync_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_W'(DB_CNT - 1)) begin
        db_d[i]  = sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Edges are taken on the next debounced level so pulses land on the flip edge.
  assign rise_c    = db_d & ~db_q;
  assign s2_fall_c = db_q[K_S2] & ~db_d[K_S2];

  always_comb begin
    btn_left_d  = rise_c[K_S0];
    btn_right_d = rise_c[K_S3];
  end

  // S2 press classifier; a release beats the long threshold on the same edge.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    s2_short_d = 1'b0;
    s2_long_d  = 1'b0;
    case (state_q)
      S2_IDLE: begin
        if (rise_c[K_S2]) begin
          state_d = S2_PRESSED;
          hold_d  = '0;
        end
      end
      S2_PRESSED: begin
        if (s2_fall_c) begin
          s2_short_d = 1'b1;
          state_d    = S2_IDLE;
        end else if (hold_q == HOLD_W'(LONG_CNT - 1)) begin
          s2_long_d = 1'b1;
          state_d   = S2_LONG_FIRED;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S2_LONG_FIRED: begin
        if (s2_fall_c) begin
          state_d = S2_IDLE;
        end
      end
      default: begin
        state_d = S2_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_db) begin
    if (!rst_n) begin
      meta_q      <= '0;
      sync_q      <= '0;
      db_q        <= '0;
      cnt_q       <= '0;
      state_q     <= S2_IDLE;
      hold_q      <= '0;
      btn_left_q  <= 1'b0;
      btn_right_q <= 1'b0;
      s2_short_q  <= 1'b0;
      s2_long_q   <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      db_q        <= db_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      btn_left_q  <= btn_left_d;
      btn_right_q <= btn_right_d;
      s2_short_q  <= s2_short_d;
      s2_long_q   <= s2_long_d;
    end
  end

  assign btn_left  = btn_left_q;
  assign btn_right = btn_right_q;
  assign s2_short  = s2_short_q;
  assign s2_long   = s2_long_q;
  assign s2_held   = db_q[K_S2];

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: expected pulse cycles are queued when keys are driven
// and matched against every pulse the outputs produce.
module tb_btn_event_gen;

  localparam int DB  = 3;
  localparam int LNG = 50;
  localparam int LAT = DB + 2;

  logic clk_db = 1'b0;
  logic rst_n  = 1'b0;
  logic key_s0 = 1'b0;
  logic key_s2 = 1'b0;
  logic key_s3 = 1'b0;
  logic btn_left, btn_right, s2_short, s2_long, s2_held;

  btn_event_gen #(.DB_CNT(DB), .LONG_CNT(LNG)) dut (
    .clk_db   (clk_db),
    .rst_n    (rst_n),
    .key_s0   (key_s0),
    .key_s2   (key_s2),
    .key_s3   (key_s3),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .s2_short (s2_short),
    .s2_long  (s2_long),
    .s2_held  (s2_held)
  );

  always #5 clk_db = ~clk_db;

  int cyc = 0;
  always @(posedge clk_db) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  // Output index: 0 btn_left, 1 btn_right, 2 s2_short, 3 s2_long.
  int    exp_q[4][$];
  string out_name[4] = '{"btn_left", "btn_right", "s2_short", "s2_long"};

  // Scoreboard: every high output cycle must match the head of its queue.
  always @(negedge clk_db) begin
    logic [3:0] outs;
    outs = {s2_long, s2_short, btn_right, btn_left};
    for (int i = 0; i < 4; i++) begin
      if (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s missing: actual no pulse by cycle %0d, required pulse at cycle %0d",
                 out_name[i], cyc, exp_q[i][0]);
        void'(exp_q[i].pop_front());
      end
      if (outs[i]) begin
        n_chk++;
        if (exp_q[i].size() > 0 && exp_q[i][0] == cyc) begin
          void'(exp_q[i].pop_front());
        end else begin
          n_fail++;
          $display("FAIL %s unexpected: actual pulse at cycle %0d, required next at %0d (-1 none)",
                   out_name[i], cyc, (exp_q[i].size() > 0) ? exp_q[i][0] : -1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_db);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       key_s0 = v;
      2:       key_s2 = v;
      default: key_s3 = v;
    endcase
  endtask

  typedef struct {
    int key;      // 0 = S0, 2 = S2, 3 = S3
    int hold;     // raw high cycles
    int out_idx;  // expected output, -1 none
    int from_rel; // 1: offset counted from release, 0: from press
    int ofs;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int c0;
    vecs[0] = '{0, 20, 0, 0, LAT};
    vecs[1] = '{3, 10, 1, 0, LAT};
    vecs[2] = '{2, 20, 2, 1, LAT};
    vecs[3] = '{2, 100, 3, 0, LAT + LNG};
    vecs[4] = '{0, DB - 1, -1, 0, 0};
    vecs[5] = '{0, DB, 0, 0, LAT};
    vecs[6] = '{2, LNG, 2, 1, LAT};
    vecs[7] = '{2, LNG + 1, 3, 0, LAT + LNG};
    vecs[8] = '{2, DB, 2, 1, LAT};
    vecs[9] = '{3, DB - 1, -1, 0, 0};

    tick(4);
    chk("reset btn_left", 32'(btn_left), 0);
    chk("reset btn_right", 32'(btn_right), 0);
    chk("reset s2_short", 32'(s2_short), 0);
    chk("reset s2_long", 32'(s2_long), 0);
    chk("reset s2_held", 32'(s2_held), 0);
    rst_n = 1'b1;
    tick(5);

    for (int v = 0; v < 10; v++) begin
      c0 = cyc;
      set_key(vecs[v].key, 1'b1);
      if (vecs[v].out_idx >= 0 && vecs[v].from_rel == 0)
        exp_q[vecs[v].out_idx].push_back(c0 + vecs[v].ofs);
      for (int t = 1; t <= vecs[v].hold; t++) begin
        tick(1);
        if (vecs[v].key == 2 && t == LAT + 1 && vecs[v].hold > LAT + 1)
          chk("s2_held during hold", 32'(s2_held), 1);
      end
      set_key(vecs[v].key, 1'b0);
      if (vecs[v].out_idx >= 0 && vecs[v].from_rel == 1)
        exp_q[vecs[v].out_idx].push_back(cyc + vecs[v].ofs);
      tick(20);
      if (vecs[v].key == 2) chk("s2_held after release", 32'(s2_held), 0);
    end

    // S3 bouncing 1,0,1,0 then a clean press
    for (int t = 0; t < 4; t++) begin
      key_s3 = (t % 2 == 0);
      tick(1);
    end
    key_s3 = 1'b0;
    tick(15);
    exp_q[1].push_back(cyc + LAT);
    key_s3 = 1'b1;
    tick(10);
    key_s3 = 1'b0;
    tick(20);

    // S0 and S2 together: btn_left coincides with debounced S2 rise
    c0 = cyc;
    key_s0 = 1'b1;
    key_s2 = 1'b1;
    exp_q[0].push_back(c0 + LAT);
    exp_q[3].push_back(c0 + LAT + LNG);
    tick(LAT - 1);
    chk("s2_held before rise", 32'(s2_held), 0);
    tick(1);
    chk("btn_left with s2 rise", 32'(btn_left), 1);
    chk("s2_held with btn_left", 32'(s2_held), 1);
    tick(5);
    key_s0 = 1'b0;
    tick(60 - LAT - 5);
    key_s2 = 1'b0;
    tick(20);

    // Reset in the middle of a long hold; key still held at release
    c0 = cyc;
    key_s2 = 1'b1;
    tick(LAT + 30);
    rst_n = 1'b0;
    tick(1);
    chk("rst mid-hold s2_held", 32'(s2_held), 0);
    tick(2);
    chk("rst mid-hold s2_long", 32'(s2_long), 0);
    chk("rst mid-hold s2_short", 32'(s2_short), 0);
    rst_n = 1'b1;
    c0 = cyc;
    exp_q[3].push_back(c0 + LAT + LNG);
    tick(LAT - 1);
    chk("re-press s2_held before rise", 32'(s2_held), 0);
    tick(1);
    chk("re-press s2_held at rise", 32'(s2_held), 1);
    tick(LNG + 10);
    key_s2 = 1'b0;
    tick(20);
    chk("s2_held after re-press", 32'(s2_held), 0);

    for (int i = 0; i < 4; i++)
      chk({out_name[i], " queue drained"}, 32'(exp_q[i].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
